// File: rtl/capture_ctrl.sv
// Oscilloscope acquisition sequencer: circular pre-trigger capture, level trigger, post-fill, rotated readout.
// Latency: RAM write/read ports combinational; busy/done registered, valid one cycle after the accepting edge.
// Backpressure: none; samples are taken whenever sample_valid is high. Optional auto trigger: CAPTURE_AUTO_TRIG_EN.
module capture_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    input  logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_ptr
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH-1:0] post_left;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic                  writing;
    logic                  level_hit;
    logic                  auto_hit;
    logic                  trig_hit;

    assign writing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    // Held at zero outside WAIT_TRIG, so every entry starts a fresh timeout; saturates once expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (abort || state != S_WAIT)
            to_cnt <= '0;
        else if (sample_valid && !auto_hit)
            to_cnt <= to_cnt + 1'b1;
    end

    assign auto_hit = (to_cnt >= TW'(AUTO_TIMEOUT));
`else
    assign auto_hit = 1'b0;
`endif

    assign level_hit = prev_valid && (trig_falling ?
                       (prev > trig_level && sample_data <= trig_level) :
                       (prev < trig_level && sample_data >= trig_level));
    assign trig_hit  = sample_valid && (force_trig || level_hit || auto_hit);

    assign ram_cs       = (state != S_IDLE);
    assign ram_we       = writing && sample_valid;
    assign ram_addr_in  = writing ? wr_ptr : '0;
    assign ram_data_in  = writing ? sample_data : '0;
    assign ram_oe       = (state == S_DONE);
    // Rotate so index 0 is the oldest sample of the circular capture.
    assign ram_addr_out = ram_oe ? (trig_ptr - pre_q + rd_index) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            post_left  <= '0;
            pre_q      <= '0;
            pre_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (writing && sample_valid) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev       <= sample_data;
                prev_valid <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        pre_q      <= pretrig;
                        pre_cnt    <= '0;
                        wr_ptr     <= '0;
                        prev_valid <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= (pretrig == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    if (sample_valid) begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt + 1'b1 == pre_q)
                            state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trig_hit) begin
                        trig_ptr  <= wr_ptr;
                        post_left <= ~pre_q;   // D-1-pre_q
                        if (pre_q == {ADDR_WIDTH{1'b1}}) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_valid) begin
                        post_left <= post_left - 1'b1;
                        if (post_left == ADDR_WIDTH'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: cycle vector table, directed capture scenarios, randomized captures vs a sample-list model.
// Uses a 16-deep RAM model; auto-trigger scenario only when CAPTURE_AUTO_TRIG_EN is defined.
module tb_capture_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int AT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm = 1'b0, abort = 1'b0, force_trig = 1'b0, sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0, trig_level = '0;
    logic          trig_falling = 1'b0;
    logic [AW-1:0] pretrig = '0, rd_index = '0;
    logic          ram_cs, ram_we, ram_oe, busy, done;
    logic [AW-1:0] ram_addr_in, ram_addr_out, trig_ptr;
    logic [DW-1:0] ram_data_in;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [D];

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_TIMEOUT(AT)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .force_trig(force_trig),
        .sample_valid(sample_valid), .sample_data(sample_data), .trig_level(trig_level),
        .trig_falling(trig_falling), .pretrig(pretrig), .rd_index(rd_index),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr_in(ram_addr_in),
        .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in), .busy(busy), .done(done),
        .trig_ptr(trig_ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_cs && ram_we) mem[ram_addr_in] <= ram_data_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit            arm, abort, sv, frc;
        logic [DW-1:0] d;
        bit            we, cs, busy, done;
    } vec_t;

    // Runs one capture. mode 0: ramp every cycle, 1: ramp with 1,0,1,0 gaps,
    // 2: random, 3: ramp with force on 3rd sample, 4: constant zero.
    task automatic capture(input int pre, input int lvl, input bit fall, input int mode,
                           output int t_out);
        logic [DW-1:0] hist[$];
        logic [DW-1:0] s;
        bit v, f, hit, fin, early;
        int k, t, cyc, writes;
        hist.delete();
        @(negedge clk);
        arm = 1; pretrig = AW'(pre); trig_level = DW'(lvl); trig_falling = fall;
        sample_valid = 0; force_trig = 0;
        @(posedge clk);
        @(negedge clk);
        arm = 0;
        chk("arm_busy", busy, 1);
        chk("arm_done", done, 0);
        k = 0; t = -1; cyc = 0; fin = 0; early = 0; writes = 0;
        while (!fin && cyc < 400) begin
            if (done) early = 1;
            v = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s = (mode == 2) ? DW'($urandom) : (mode == 4) ? '0 : DW'(k * 16);
            f = (mode == 3 && k == 2) || (mode == 2 && (k >= pre + 30 || $urandom_range(0, 15) == 0));
            sample_valid = v; sample_data = s; force_trig = f;
            if (v) begin
                if (t < 0 && k >= pre) begin
                    hit = f;
                    if (k > 0) hit |= fall ? (hist[k-1] > lvl && s <= lvl) : (hist[k-1] < lvl && s >= lvl);
`ifdef CAPTURE_AUTO_TRIG_EN
                    if (k - pre >= AT) hit = 1;
`endif
                    if (hit) t = k;
                end
                hist.push_back(s);
                if (t >= 0 && k == t + (D - 1 - pre)) fin = 1;
                k++;
            end
            #1;
            if (ram_we) writes++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        sample_valid = 0; force_trig = 0;
        if (!fin) begin
            bad++; total++;
            $display("FAIL capture_timeout: got=no_done expected=done within 400 cycles");
            t_out = -1;
            return;
        end
        chk("no_early_done", early, 0);
        chk("done_set", done, 1);
        chk("busy_clr", busy, 0);
        chk("oe_in_done", ram_oe, 1);
        chk("write_count", writes, k);
        chk("trig_ptr", trig_ptr, t % D);
        for (int i = 0; i < D; i++) begin
            rd_index = AW'(i);
            #1;
            chk("readout", mem[ram_addr_out], hist[t - pre + i]);
        end
        t_out = t;
    endtask

    initial begin
        vec_t tbl[8];
        int   t;

        // pretrig=0, level out of reach: force triggers on 3rd sample, then abort in POST
        tbl[0] = '{1, 0, 0, 0, 8'd0,  0, 0, 1, 0};
        tbl[1] = '{0, 0, 1, 0, 8'd10, 1, 1, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 8'd99, 0, 1, 1, 0};
        tbl[3] = '{0, 0, 1, 0, 8'd20, 1, 1, 1, 0};
        tbl[4] = '{0, 0, 1, 1, 8'd30, 1, 1, 1, 0};
        tbl[5] = '{1, 0, 1, 0, 8'd40, 1, 1, 1, 0};
        tbl[6] = '{1, 1, 1, 0, 8'd50, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 8'd60, 0, 0, 0, 0};

        rst = 1; sample_valid = 1; sample_data = 8'h5A; rd_index = 4'd3;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_addr_in", ram_addr_in, 0);
        chk("rst_addr_out", ram_addr_out, 0);
        chk("rst_data_in", ram_data_in, 0);
        chk("rst_trig_ptr", trig_ptr, 0);
        @(negedge clk);
        rst = 0; sample_valid = 0; rd_index = 0;
        pretrig = 0; trig_level = 8'd200; trig_falling = 0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            arm = tbl[i].arm; abort = tbl[i].abort; sample_valid = tbl[i].sv;
            force_trig = tbl[i].frc; sample_data = tbl[i].d;
            #1;
            chk("vec_we", ram_we, tbl[i].we);
            chk("vec_cs", ram_cs, tbl[i].cs);
            @(posedge clk);
            #1;
            chk("vec_busy", busy, tbl[i].busy);
            chk("vec_done", done, tbl[i].done);
            if (i == 4) chk("vec_force_trig_ptr", trig_ptr, 2);
        end
        chk("abort_oe", ram_oe, 0);
        @(negedge clk);
        arm = 0; abort = 0; sample_valid = 0; force_trig = 0;

        capture(4, 128, 0, 0, t);
        chk("ramp_trig_ptr", trig_ptr, 8);
        rd_index = 4; #1;
        chk("ramp_idx4", mem[ram_addr_out], 128);
        rd_index = 0; #1;
        chk("ramp_idx0", mem[ram_addr_out], 64);

        capture(4, 128, 0, 1, t);
        rd_index = 4; #1;
        chk("gap_idx4", mem[ram_addr_out], 128);
        rd_index = 15; #1;
        chk("gap_idx15", mem[ram_addr_out], 48);

        capture(0, 255, 0, 3, t);
        rd_index = 0; #1;
        chk("force_idx0", mem[ram_addr_out], 32);

        capture(15, 128, 0, 0, t);
        chk("pre15_trig_ptr", trig_ptr, 8);

        for (int r = 0; r < 6; r++)
            capture($urandom_range(0, D - 1), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 2, t);

`ifdef CAPTURE_AUTO_TRIG_EN
        capture(2, 128, 0, 4, t);
        chk("auto_trig_ptr", trig_ptr, 10);
`endif

        // asynchronous reset while waiting for a trigger that cannot occur
        @(negedge clk);
        arm = 1; pretrig = 4'd2; trig_level = 8'd255; trig_falling = 0;
        @(negedge clk);
        arm = 0; sample_valid = 1; sample_data = 8'd1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        sample_data = 8'h77;
        #2 rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cs", ram_cs, 0);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_addr_in", ram_addr_in, 0);
        chk("mid_rst_data_in", ram_data_in, 0);
        chk("mid_rst_oe", ram_oe, 0);
        @(negedge clk);
        rst = 0; sample_valid = 0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Acquisition sequencer for the oscilloscope sample RAM (single-port, synchronous write, asynchronous read, output enable). Drives the RAM write port while capturing a circular pre-trigger history, detects a level trigger, and finishes the post-trigger fill. It then hands the RAM read port to the display/readout side with addresses rotated so that index 0 is the oldest captured sample.

## Interface
- DATA_WIDTH, 8, sample and RAM word width
- ADDR_WIDTH, 8, RAM address width; depth D = 2^ADDR_WIDTH
- AUTO_TIMEOUT, 1024, samples waited in WAIT_TRIG before a forced trigger (only with CAPTURE_AUTO_TRIG_EN)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  start a capture; honoured only in IDLE or DONE
- abort  in  1  return to IDLE from any state; wins over arm
- force_trig  in  1  trigger on the next valid sample in WAIT_TRIG
- sample_valid  in  1  sample_data qualifier
- sample_data  in  DATA_WIDTH  unsigned ADC sample
- trig_level  in  DATA_WIDTH  unsigned threshold
- trig_falling  in  1  0: rising-edge trigger, 1: falling-edge trigger
- pretrig  in  ADDR_WIDTH  pre-trigger sample count, 0..D-1; sampled on arm
- rd_index  in  ADDR_WIDTH  readout index, 0 = oldest sample
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_addr_in  out  ADDR_WIDTH  RAM write address
- ram_addr_out  out  ADDR_WIDTH  RAM read address
- ram_data_in  out  DATA_WIDTH  RAM write data
- busy  out  1  high in PRE, WAIT_TRIG, and POST
- done  out  1  high in DONE
- trig_ptr  out  ADDR_WIDTH  RAM address of the trigger sample

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- arm in IDLE/DONE:
  - latch pretrig into pre_q; clear wr_ptr to 0 and clear prev_valid.
  - Go to PRE, or directly to WAIT_TRIG if pre_q==0.
- Write behaviour, all in PRE, WAIT_TRIG, and POST:
  - ram_we = sample_valid; ram_addr_in = wr_ptr; ram_data_in = sample_data.
  - On each valid sample, wr_ptr increments modulo D.
- PRE:
  - Count valid samples.
  - After pre_q samples have been written, go to WAIT_TRIG.
- WAIT_TRIG:
  - Keep writing circularly; the oldest history is overwritten.
  - Trigger fires on a valid sample when one of these holds:
    - rising: prev_valid && prev < trig_level && sample >= trig_level
    - falling: prev_valid && prev > trig_level && sample <= trig_level
    - force_trig is high
  - The trigger sample is written. trig_ptr takes that sample's write address.
  - post_left is loaded with D-1-pre_q.
  - Next state is POST, or DONE if post_left==0.
- prev and prev_valid:
  - prev updates on every valid sample in the write states.
  - prev_valid is set by the first such sample after arm.
- POST:
  - Each valid sample decrements post_left.
  - The write that brings post_left to 0 moves the block to DONE.
- DONE:
  - ram_oe=1.
  - ram_addr_out = (trig_ptr - pre_q + rd_index) mod D.
  - start address = trig_ptr - pre_q, wrapping modulo D.
- ram_cs = 1 in every state except IDLE. In IDLE, ram_oe=0 (RAM data_out is high-Z) and ram_addr_out=0.
- Total samples per capture: exactly D, with the trigger sample at rd_index pre_q.

## Timing
- Reset values:
  - state IDLE; wr_ptr, trig_ptr, post_left, and pre_q all 0; prev_valid 0.
  - Outputs: busy=0, done=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr_in=0, ram_addr_out=0, ram_data_in=0.
- ram_we, ram_addr_in, and ram_data_in are combinational from registered state/pointer plus sample_* inputs. The RAM write completes on the same clk edge that accepts the sample.
- State transitions take effect on the edge that accepts the qualifying sample.
- busy/done are registered and reflect the new state one cycle after that edge.
- Read path is combinational: ram_addr_out follows rd_index with zero cycles of latency.
- Boundary and conflict rules:
  - abort and arm in the same cycle: IDLE.
  - arm while busy: ignored.
  - arm in DONE: re-capture; done drops the next cycle.
  - sample_valid low: no state or pointer change, and no prev update.
  - force_trig with no valid sample: no effect.
  - rst mid-capture: immediate return to reset values; no partial-capture flag.

## Configuration
- CAPTURE_AUTO_TRIG_EN defined:
  - A timeout counter, reset on entry to WAIT_TRIG, counts valid samples spent there.
  - On reaching AUTO_TIMEOUT, the next valid sample triggers as if force_trig were high.
- CAPTURE_AUTO_TRIG_EN undefined: no counter is built; WAIT_TRIG waits indefinitely, and AUTO_TIMEOUT is ignored.

## Test plan
- ADDR_WIDTH=4, pretrig=4, level=128, rising, ramp 0,16,32,… every cycle:
  - Trigger on sample 128 (prev 112).
  - Exactly 11 more samples are written after the trigger sample.
  - done=1; reading rd_index 0..15 gives 64..304 mod 256 in steps of 16, with 128 at index 4.
- pretrig=0, force_trig pulsed with the third sample:
  - trig_ptr=2; rd_index 0 reads the trigger sample.
- pretrig=15 (D-1): trigger → DONE immediately after the trigger sample, with no POST cycles.
- Gaps: sample_valid toggling 1,0,1,0 throughout a capture must yield the same RAM contents and ordering as the gap-free run.
- Abort and reset:
  - abort during POST → IDLE, with ram_we=0 and ram_oe=0.
  - rst asserted mid-WAIT_TRIG clears all outputs asynchronously.
- CAPTURE_AUTO_TRIG_EN, AUTO_TIMEOUT=8, constant input 0: trigger occurs on the 9th valid sample in WAIT_TRIG.
